// File: rtl/mux_nx1_stream.sv
// rtl/mux_nx1_stream.sv - N:1 packet-locked valid/ready stream mux with a registered output
// Optional round-robin channel selection replaces sel when MUX_STREAM_RR_ARB_EN is defined.
module mux_nx1_stream #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic [SEL_W-1:0]   cur_ch,
    output logic               sel_err
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cur_ch_q, cur_ch_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               sel_err_q, sel_err_d;

    logic [WIDTH-1:0]   ch_data;
    logic               ch_valid;
    logic               ch_last;
    logic               ch_ready;
    logic               accept;

    // Locked channel's inputs, selected with constant slices only.
    always_comb begin
        ch_data  = '0;
        ch_valid = 1'b0;
        ch_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cur_ch_q == SEL_W'(i)) begin
                ch_data  = in_data[i*WIDTH +: WIDTH];
                ch_valid = in_valid[i];
                ch_last  = in_last[i];
            end
        end
    end

`ifdef MUX_STREAM_RR_ARB_EN
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] rr_pick;
    logic             rr_hit;
    logic             unused_sel;

    assign unused_sel = ^sel;

    // Scan downwards so the first valid channel at or after rr_ptr wins.
    always_comb begin
        rr_hit  = 1'b0;
        rr_pick = '0;
        rr_idx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            rr_idx = SEL_W'((int'(rr_ptr_q) + k) % N);
            if (in_valid[rr_idx]) begin
                rr_hit  = 1'b1;
                rr_pick = rr_idx;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && rr_hit) begin
            rr_ptr_d = (rr_pick == SEL_W'(N - 1)) ? '0 : rr_pick + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);
    logic sel_in_range;
    logic sel_valid;

    assign sel_in_range = ({1'b0, sel} < N_EXT);

    always_comb begin
        sel_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_valid = in_valid[i];
            end
        end
    end
`endif

    assign ch_ready = (state_q == LOCK) && (!out_valid_q || out_ready);
    assign accept   = ch_valid && ch_ready;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (cur_ch_q == SEL_W'(i)) begin
                in_ready[i] = ch_ready;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        sel_err_d   = sel_err_q;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
`ifdef MUX_STREAM_RR_ARB_EN
                if (rr_hit) begin
                    cur_ch_d = rr_pick;
                    state_d  = LOCK;
                end
`else
                if (!sel_in_range) begin
                    sel_err_d = 1'b1;
                end else if (sel_valid) begin
                    cur_ch_d = sel;
                    state_d  = LOCK;
                end
`endif
            end
            LOCK: begin
                // An accepted beat overwrites the register, which also covers drain+fill.
                if (accept) begin
                    out_data_d  = ch_data;
                    out_last_d  = ch_last;
                    out_valid_d = 1'b1;
                    if (ch_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_ch_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == LOCK);
    assign cur_ch    = cur_ch_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb/tb_mux_nx1_stream.sv - directed and randomized bench for mux_nx1_stream (N=4 main, N=3 range check)
module tb_mux_nx1_stream;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid, in_last, in_ready;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic            out_valid, out_last, out_ready, busy, sel_err;
    logic [SW-1:0]   cur_ch;

    logic [3*W-1:0]  d3;
    logic [2:0]      v3, l3, r3;
    logic [1:0]      sel3, cc3;
    logic [W-1:0]    od3;
    logic            ov3, ol3, ordy3, busy3, se3;

    int nvec = 0;
    int nerr = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    mux_nx1_stream #(.WIDTH(W), .N(N)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .cur_ch(cur_ch), .sel_err(sel_err)
    );

    mux_nx1_stream #(.WIDTH(W), .N(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_last(l3),
        .in_ready(r3), .sel(sel3), .out_data(od3), .out_valid(ov3),
        .out_last(ol3), .out_ready(ordy3), .busy(busy3), .cur_ch(cc3), .sel_err(se3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic v, input logic [31:0] d, input logic l);
        in_valid[ch]         = v;
        in_data[ch*W +: W]   = d;
        in_last[ch]          = l;
    endtask

    // One clock with scoreboard checking of whatever leaves the output port.
    task automatic step_chk(input int c, output bit hs);
        logic [31:0] od;
        logic        ol;
        bit          ohs;
        logic [32:0] e;
        #1;
        if (c >= 0) chk("rdy_other", in_ready & ~(4'b0001 << c), 0);
        hs  = (c >= 0) && in_valid[c] && in_ready[c];
        ohs = out_valid && out_ready;
        od  = out_data;
        ol  = out_last;
        @(posedge clk);
        #1;
        if (ohs) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", od, e[31:0]);
                chk("sb_last", {31'b0, ol}, {31'b0, e[32]});
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, {31'b0, out_last}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_in_ready"}, {28'b0, in_ready}, 0);
        chk({tag, "_cur_ch"}, {30'b0, cur_ch}, 0);
        chk({tag, "_sel_err"}, {31'b0, sel_err}, 0);
        chk({tag, "_sel_err3"}, {31'b0, se3}, 0);
    endtask

    initial begin
        logic [31:0] beats[8];
        int          c, len, bi, guard;
        bit          hs;

        rst = 1'b1; in_data = '0; in_valid = '0; in_last = '0; sel = '0; out_ready = 1'b1;
        d3 = '0; v3 = '0; l3 = '0; sel3 = '0; ordy3 = 1'b1;
        tick(); tick();
        check_reset_outputs("rst_init");
        rst = 1'b0;

`ifdef MUX_STREAM_RR_ARB_EN
        // All channels always offering single-beat packets: lock order rotates.
        for (int i = 0; i < N; i++) drive(i, 1'b1, 32'hC0 + i, 1'b1);
        sel = 2'd3;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_busy", {31'b0, busy}, 1);
            chk("rr_cur_ch", {30'b0, cur_ch}, k % N);
            tick();
            chk("rr_idle", {31'b0, busy}, 0);
            chk("rr_data", out_data, 32'hC0 + (k % N));
            chk("rr_sel_err", {31'b0, sel_err}, 0);
            sel = 2'($urandom_range(0, 3));
        end
        in_valid = '0;
        tick();
`else
        // Three-beat packet on ch2 with the output free.
        sel = 2'd2; drive(2, 1'b1, 32'hAAAA_0001, 1'b0);
        #1;
        chk("t2_idle_rdy", {28'b0, in_ready}, 0);
        tick();
        chk("t2_busy", {31'b0, busy}, 1);
        chk("t2_cur_ch", {30'b0, cur_ch}, 2);
        chk("t2_lock_no_beat", {31'b0, out_valid}, 0);
        chk("t2_rdy", {28'b0, in_ready}, 4'b0100);
        tick();
        chk("t2_A", out_data, 32'hAAAA_0001);
        chk("t2_A_last", {31'b0, out_last}, 0);
        drive(2, 1'b1, 32'hBBBB_0002, 1'b0);
        tick();
        chk("t2_B", out_data, 32'hBBBB_0002);
        drive(2, 1'b1, 32'hCCCC_0003, 1'b1);
        tick();
        chk("t2_C", out_data, 32'hCCCC_0003);
        chk("t2_C_last", {31'b0, out_last}, 1);
        chk("t2_busy_fall", {31'b0, busy}, 0);
        in_valid = '0;
        tick();
        chk("t2_drained", {31'b0, out_valid}, 0);

        // Same packet with output back-pressure after A.
        drive(2, 1'b1, 32'hAAAA_0001, 1'b0);
        tick(); tick();
        chk("t3_A", out_data, 32'hAAAA_0001);
        drive(2, 1'b1, 32'hBBBB_0002, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_stall_rdy", {28'b0, in_ready}, 0);
            tick();
            chk("t3_hold_data", out_data, 32'hAAAA_0001);
            chk("t3_hold_valid", {31'b0, out_valid}, 1);
        end
        out_ready = 1'b1;
        tick();
        chk("t3_B", out_data, 32'hBBBB_0002);
        drive(2, 1'b1, 32'hCCCC_0003, 1'b1);
        tick();
        chk("t3_C", out_data, 32'hCCCC_0003);
        in_valid = '0;
        tick();
        chk("t3_idle", {31'b0, busy}, 0);

        // Lock on ch1, sel moves to ch3 mid-packet, ch1 pauses.
        sel = 2'd1; drive(1, 1'b1, 32'h1111_0001, 1'b0); drive(3, 1'b1, 32'h3333_0003, 1'b1);
        tick();
        chk("t4_cur_ch", {30'b0, cur_ch}, 1);
        sel = 2'd3;
        tick();
        chk("t4_D1", out_data, 32'h1111_0001);
        chk("t4_rdy", {28'b0, in_ready}, 4'b0010);
        in_valid[1] = 1'b0;
        tick(); tick();
        chk("t4_gap_busy", {31'b0, busy}, 1);
        chk("t4_gap_rdy", {28'b0, in_ready}, 4'b0010);
        chk("t4_gap_drain", {31'b0, out_valid}, 0);
        drive(1, 1'b1, 32'h1111_0002, 1'b1);
        tick();
        chk("t4_D2", out_data, 32'h1111_0002);
        chk("t4_release", {31'b0, busy}, 0);
        in_valid[1] = 1'b0;
        tick();
        chk("t4_ch3_lock", {30'b0, cur_ch}, 3);
        tick();
        chk("t4_ch3_data", out_data, 32'h3333_0003);
        in_valid = '0;
        tick();

        // Out-of-range sel on the 3-channel instance.
        sel3 = 2'd3; v3 = 3'b111; l3 = 3'b111; d3 = {32'h3, 32'h2, 32'h1};
        tick();
        chk("t5_sel_err", {31'b0, se3}, 1);
        chk("t5_no_lock", {31'b0, busy3}, 0);
        chk("t5_rdy", {29'b0, r3}, 0);
        sel3 = 2'd0;
        tick();
        chk("t5_sticky", {31'b0, se3}, 1);
        chk("t5_lock0", {31'b0, busy3}, 1);
        v3 = '0;
        tick();
`endif

        // Reset mid-packet clears everything before the next edge.
        sel = 2'd0; drive(0, 1'b1, 32'hDEAD_0000, 1'b0);
        tick(); tick();
        chk("t1_pre_valid", {31'b0, out_valid}, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t1_async");
        in_valid = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("t1_after_busy", {31'b0, busy}, 0);
        chk("t1_after_valid", {31'b0, out_valid}, 0);

`ifndef MUX_STREAM_RR_ARB_EN
        // Random packets; model: output is the concatenation of the selected packets.
        for (int p = 0; p < 40; p++) begin
            c   = $urandom_range(0, N - 1);
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                beats[b] = $urandom;
                exp_q.push_back({(b == len - 1), beats[b]});
            end
            sel = 2'(c); bi = 0; guard = 0;
            while (bi < len && guard < 200) begin
                for (int i = 0; i < N; i++)
                    if (i != c) drive(i, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
                drive(c, ($urandom_range(0, 3) != 0), beats[bi], (bi == len - 1));
                out_ready = ($urandom_range(0, 3) != 0);
                step_chk(c, hs);
                if (hs) bi++;
                guard++;
            end
            if (guard >= 200) chk("rand_timeout", 0, 1);
        end
        in_valid = '0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step_chk(-1, hs);
        chk("rand_all_drained", exp_q.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
